snap_capture_ctrl: RTL and testbench
====================================

# snap_capture_ctrl

Write-side controller for a snapshot capture buffer. It arms on a software request and waits for a qualified trigger. After an optional post-trigger offset, it streams valid fabric samples into port A of the dual-port snapshot BRAM (128-bit word, 12-bit word address); the processor later reads the captured words out over port B. It also exports done/armed status and the number of words captured, for the software register map.

## Interface
- DATA_WIDTH, 128, sample/BRAM word width
- ADDR_WIDTH, 12, BRAM word-address width; depth = 2^ADDR_WIDTH words
- clk  in  1  capture clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- ctrl_arm  in  1  software arm; rising edge (0→1 between consecutive cycles) starts a capture
- ctrl_trig_en  in  1  1: wait for trig; 0: trigger on first valid sample after arm
- ctrl_offset  in  32  valid samples to discard after the trigger; latched at arm
- ctrl_len  in  ADDR_WIDTH+1  words to capture, 1..2^ADDR_WIDTH; 0 or >2^ADDR_WIDTH means full depth; latched at arm
- din  in  DATA_WIDTH  sample data
- din_valid  in  1  din qualifier
- trig  in  1  trigger, sampled only when din_valid=1
- bram_we  out  1  port A write enable
- bram_addr  out  ADDR_WIDTH  port A word address
- bram_wr_data  out  DATA_WIDTH  port A write data
- status_armed  out  1  high in ARMED/DELAY/CAPTURE
- status_done  out  1  capture complete
- status_count  out  ADDR_WIDTH+1  words written in current/last capture

## Operation
- The state machine has states IDLE, ARMED, DELAY, CAPTURE and DONE.
- Arm edge detector: registered copy of ctrl_arm; the edge fires when the current value is 1 and the registered value is 0.
- Arm edge, in any state:
  - latch offset and length;
  - clear the count, the offset counter and status_done;
  - go to ARMED.
- ARMED: a trigger event is a cycle with din_valid=1 and (trig=1 or ctrl_trig_en=0).
  - On a trigger event with offset 0: go to CAPTURE, and the trigger-cycle sample is written as word 0.
  - On a trigger event with offset N>0: the trigger-cycle sample is discarded as discard 1 of N; go to DELAY, or go straight to CAPTURE if N=1.
- DELAY: each din_valid cycle discards one sample. After the Nth discard, go to CAPTURE; the next valid sample is word 0.
- CAPTURE: each din_valid cycle performs one write at address = count[ADDR_WIDTH-1:0], then count increments. When count reaches the length, go to DONE. Addresses never wrap.
- DONE: status_done=1; no writes. Hold until the next arm edge.
- trig with din_valid=0 is ignored.

## Timing
- Reset values (asynchronous, immediate): bram_we=0, bram_addr=0, bram_wr_data=0, status_armed=0, status_done=0, status_count=0, state IDLE, arm-edge register=0.
- Write latency is one cycle: a sample accepted at edge k appears on bram_we/bram_addr/bram_wr_data during cycle k+1.
- bram_we is a single-cycle pulse per accepted sample.
- bram_addr and bram_wr_data hold their last values while bram_we=0.
- status_count updates on the same edge that asserts the corresponding bram_we.
- status_done rises the cycle after the final bram_we pulse.
- status_armed falls on that same cycle.
- status_armed rises the cycle after the arm edge.
- Arm edge during CAPTURE aborts the capture. The cycle after the edge:
  - bram_we=0, count=0, status_armed=1, status_done=0, state ARMED;
  - no write is issued for a sample coincident with the arm edge.
- Reset mid-capture: all outputs go to their reset values immediately, and no further writes occur until the next arm edge after rst_n is released.
- Length = 2^ADDR_WIDTH: the final write goes to address 2^ADDR_WIDTH−1, and status_count = 2^ADDR_WIDTH.

## Test plan
- ctrl_trig_en=0, offset 0, len 0, din_valid continuous, din = incrementing counter starting at 0x10 on the arm cycle+1 → 4096 writes:
  - addr 0..4095;
  - addr 0 data 0x10;
  - status_count=4096;
  - status_done high the cycle after the last write.
- ctrl_trig_en=1, offset 3, len 4; trig on the sample 0xA0, then samples 0xA1, 0xA2, ... → writes 0xA3..0xA6 at addr 0..3; status_count=4.
- len 5, din_valid toggling 1,0,1,0 → exactly 5 bram_we pulses at addr 0..4, each one cycle after its valid sample.
- trig=1 while din_valid=0, then trig=0 while din_valid=1 → no writes; status_armed stays 1; status_done=0.
- Re-arm after 10 of 20 writes → count returns to 0; the next capture restarts at addr 0; status_done stays 0 until 20 new writes complete.
- rst_n low for 1 cycle during CAPTURE → all outputs 0 immediately; arm edge with ctrl_trig_en=0 after release → a normal capture starting at addr 0.

Source files
------------

// File: rtl/snap_capture_ctrl.sv
// Write-side controller for the snapshot capture BRAM: arm, trigger, optional
// post-trigger discard, then stream valid samples into port A with status export.
module snap_capture_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_arm,
    input  logic                  ctrl_trig_en,
    input  logic [31:0]           ctrl_offset,
    input  logic [ADDR_WIDTH:0]   ctrl_len,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  trig,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic                  status_armed,
    output logic                  status_done,
    output logic [ADDR_WIDTH:0]   status_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_CNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic                    arm_q;
    logic [31:0]             offset_q, offset_d;
    logic [31:0]             disc_q, disc_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    armed_q, armed_d;
    logic                    done_q, done_d;

    logic                    arm_edge;
    logic                    trig_event;
    logic                    write_now;

    assign arm_edge   = ctrl_arm & ~arm_q;
    assign trig_event = din_valid & (trig | ~ctrl_trig_en);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        disc_d    = disc_q;
        len_d     = len_q;
        count_d   = count_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        write_now = 1'b0;

        // An arm edge restarts from any state and suppresses a coincident write.
        if (arm_edge) begin
            offset_d = ctrl_offset;
            len_d    = ((ctrl_len == '0) || (ctrl_len > FULL_LEN)) ? FULL_LEN : ctrl_len;
            count_d  = '0;
            disc_d   = '0;
            state_d  = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (trig_event) begin
                        if (offset_q == 32'd0) begin
                            write_now = 1'b1;
                        end else if (offset_q == 32'd1) begin
                            state_d = S_CAPTURE;
                        end else begin
                            disc_d  = 32'd1;
                            state_d = S_DELAY;
                        end
                    end
                end
                S_DELAY: begin
                    if (din_valid) begin
                        disc_d = disc_q + 32'd1;
                        if ((disc_q + 32'd1) == offset_q) begin
                            state_d = S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    write_now = din_valid;
                end
                default: ;
            endcase
        end

        if (write_now) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_WIDTH-1:0];
            data_d  = din;
            count_d = count_q + ONE_CNT;
            state_d = ((count_q + ONE_CNT) == len_q) ? S_DONE : S_CAPTURE;
        end

        // Armed stays up through the final write pulse; done follows one cycle later.
        armed_d = (state_d == S_ARMED) || (state_d == S_DELAY) || (state_d == S_CAPTURE)
                  || ((state_d == S_DONE) && (state_q != S_DONE));
        done_d  = (state_d == S_DONE) && (state_q == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            arm_q    <= 1'b0;
            offset_q <= '0;
            disc_q   <= '0;
            len_q    <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            armed_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            arm_q    <= ctrl_arm;
            offset_q <= offset_d;
            disc_q   <= disc_d;
            len_q    <= len_d;
            count_q  <= count_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            armed_q  <= armed_d;
            done_q   <= done_d;
        end
    end

    assign bram_we      = we_q;
    assign bram_addr    = addr_q;
    assign bram_wr_data = data_q;
    assign status_armed = armed_q;
    assign status_done  = done_q;
    assign status_count = count_q;

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Self-checking bench for snap_capture_ctrl: directed scenarios plus randomized
// sessions, compared every cycle against a sample-index based reference model.
module tb_snap_capture_ctrl;

    localparam int DW   = 128;
    localparam int AW   = 12;
    localparam int FULL = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          ctrl_arm;
    logic          ctrl_trig_en;
    logic [31:0]   ctrl_offset;
    logic [AW:0]   ctrl_len;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          trig;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wr_data;
    logic          status_armed;
    logic          status_done;
    logic [AW:0]   status_count;

    snap_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_arm     (ctrl_arm),
        .ctrl_trig_en (ctrl_trig_en),
        .ctrl_offset  (ctrl_offset),
        .ctrl_len     (ctrl_len),
        .din          (din),
        .din_valid    (din_valid),
        .trig         (trig),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_wr_data (bram_wr_data),
        .status_armed (status_armed),
        .status_done  (status_done),
        .status_count (status_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a capture is the window [offset, offset+len) of the valid
    // samples counted from the trigger sample (index 0) after the last arm edge.
    bit            m_prev_arm;
    bit            m_session;
    bit            m_trig_seen;
    bit            m_finishing;
    longint        m_nvalid;
    longint        m_offset;
    int            m_len;
    int            m_count;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_armed;
    logic          e_done;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_prev_arm  = 1'b0;
        m_session   = 1'b0;
        m_trig_seen = 1'b0;
        m_finishing = 1'b0;
        m_nvalid    = 0;
        m_offset    = 0;
        m_len       = 0;
        m_count     = 0;
        e_we        = 1'b0;
        e_addr      = '0;
        e_data      = '0;
        e_armed     = 1'b0;
        e_done      = 1'b0;
    endtask

    task automatic model_edge();
        bit arm_rise;
        arm_rise   = ctrl_arm && !m_prev_arm;
        m_prev_arm = ctrl_arm;
        e_we       = 1'b0;
        if (arm_rise) begin
            m_offset    = longint'(ctrl_offset);
            m_len       = ((ctrl_len == 0) || (int'(ctrl_len) > FULL)) ? FULL : int'(ctrl_len);
            m_session   = 1'b1;
            m_trig_seen = 1'b0;
            m_finishing = 1'b0;
            m_nvalid    = 0;
            m_count     = 0;
            e_armed     = 1'b1;
            e_done      = 1'b0;
        end else if (m_finishing) begin
            m_finishing = 1'b0;
            m_session   = 1'b0;
            e_armed     = 1'b0;
            e_done      = 1'b1;
        end else if (m_session && din_valid) begin
            if (!m_trig_seen && (trig || !ctrl_trig_en))
                m_trig_seen = 1'b1;
            if (m_trig_seen) begin
                if (m_nvalid >= m_offset) begin
                    e_we    = 1'b1;
                    e_addr  = AW'(m_nvalid - m_offset);
                    e_data  = din;
                    m_count = m_count + 1;
                    if (m_count == m_len)
                        m_finishing = 1'b1;
                end
                m_nvalid = m_nvalid + 1;
            end
        end
    endtask

    task automatic check_outputs();
        check("bram_we",      bram_we,      e_we);
        check("bram_addr",    bram_addr,    e_addr);
        check("bram_wr_data", bram_wr_data, e_data);
        check("status_count", status_count, m_count);
        check("status_armed", status_armed, e_armed);
        check("status_done",  status_done,  e_done);
    endtask

    task automatic step(input bit arm, input bit v, input bit t, input logic [DW-1:0] d);
        ctrl_arm  = arm;
        din_valid = v;
        trig      = t;
        din       = d;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_cfg(input bit trig_en, input int offset, input int len);
        ctrl_trig_en = trig_en;
        ctrl_offset  = offset;
        ctrl_len     = (AW+1)'(len);
    endtask

    // Reset lands mid-cycle so outputs must clear without a clock edge.
    task automatic async_reset();
        #2;
        ctrl_arm  = 1'b0;
        din_valid = 1'b0;
        trig      = 1'b0;
        rst_n     = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        rst_n     = 1'b0;
        ctrl_arm  = 1'b0;
        din_valid = 1'b0;
        trig      = 1'b0;
        din       = '0;
        set_cfg(1'b0, 0, 0);
        model_reset();
        #1;
        check_outputs();
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);

        // Full-depth capture, free-running trigger, incrementing data from 0x10.
        set_cfg(1'b0, 0, 0);
        step(1, 1, 0, DW'(128'hDEAD));
        for (int i = 0; i < FULL + 4; i++)
            step(0, 1, 0, DW'(32'h10 + i));
        check("full_count", status_count, 13'd4096);
        check("full_last_addr", bram_addr, 12'd4095);
        check("full_done", status_done, 1'b1);

        // Qualified trigger with offset 3, length 4.
        set_cfg(1'b1, 3, 4);
        step(1, 0, 0, '0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, DW'(32'h90 + i));
        step(0, 1, 1, DW'(32'hA0));
        for (int i = 1; i < 9; i++)
            step(0, 1, 0, DW'(32'hA0 + i));
        check("off3_count", status_count, 13'd4);
        check("off3_last_data", bram_wr_data, 128'hA6);
        check("off3_last_addr", bram_addr, 12'd3);

        // Length 5 with din_valid toggling.
        set_cfg(1'b0, 0, 5);
        step(1, 0, 0, '0);
        for (int i = 0; i < 14; i++)
            step(0, (i % 2) == 0, 0, DW'(32'hB0 + i));
        check("toggle_count", status_count, 13'd5);

        // Trigger without valid, then valid without trigger: nothing is captured.
        set_cfg(1'b1, 0, 3);
        step(1, 0, 0, '0);
        step(0, 0, 1, DW'(32'hC0));
        for (int i = 1; i < 5; i++)
            step(0, 1, 0, DW'(32'hC0 + i));
        check("notrig_armed", status_armed, 1'b1);
        check("notrig_done", status_done, 1'b0);
        check("notrig_count", status_count, 13'd0);

        // Re-arm after 10 of 20 writes; the coincident sample must not be written.
        set_cfg(1'b0, 0, 20);
        step(0, 0, 0, '0);
        step(1, 0, 0, '0);
        for (int i = 0; i < 10; i++)
            step(0, 1, 0, rand_data());
        step(1, 1, 0, rand_data());
        check("rearm_we", bram_we, 1'b0);
        check("rearm_count", status_count, 13'd0);
        check("rearm_armed", status_armed, 1'b1);
        for (int i = 0; i < 25; i++)
            step(0, 1, 0, rand_data());
        check("rearm_final_count", status_count, 13'd20);
        check("rearm_final_done", status_done, 1'b1);

        // Reset in the middle of a capture, then a clean capture afterwards.
        set_cfg(1'b0, 0, 8);
        step(1, 0, 0, '0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, rand_data());
        async_reset();
        step(0, 1, 0, rand_data());
        step(0, 1, 0, rand_data());
        set_cfg(1'b0, 0, 6);
        step(1, 0, 0, '0);
        for (int i = 0; i < 10; i++)
            step(0, 1, 0, rand_data());
        check("post_reset_count", status_count, 13'd6);
        check("post_reset_done", status_done, 1'b1);

        // Randomized sessions; configuration changes after arm must be ignored.
        for (int s = 0; s < 40; s++) begin
            set_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                    int'($urandom_range(1, 12)));
            step(0, 1'($urandom_range(0, 1)), 0, rand_data());
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_data());
            set_cfg(1'(ctrl_trig_en), int'($urandom_range(0, 5)), int'($urandom_range(1, 12)));
            for (int c = 0; c < 40; c++) begin
                if (s == 17 && c == 9)
                    async_reset();
                step(($urandom_range(0, 59) == 0),
                     ($urandom_range(0, 9) < 7),
                     ($urandom_range(0, 4) == 0),
                     rand_data());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
